tone_period_detector: RTL and testbench

//   Receive side of the tone generator: measures the period of an incoming

---
 rtl/tone_pkg.sv | 12 +
 rtl/edge_sync.sv | 21 ++
 rtl/tone_period_detector.sv | 109 ++++++++++
 tb/tb_tone_period_detector.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg: nominal tone periods, note-code type and detector FSM states.
package tone_pkg;
    localparam int P0 = 888;
    localparam int P1 = 670;
    localparam int P2 = 560;
    localparam int P3 = 444;
    typedef logic [1:0] note_t;
    typedef enum logic {IDLE, MEASURE} state_t;
    function automatic int nominal(input note_t k);
        return (k == 2'd0) ? P0 : (k == 2'd1) ? P1 : (k == 2'd2) ? P2 : P3;
    endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-FF synchronizer plus registered rising-edge pulse.
// The pulse appears 3 clocks after the asynchronous input edge.
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    logic [2:0] sync_q;
    logic       rise_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end
    assign rise_o = rise_q;
endmodule

// File: rtl/tone_period_detector.sv
// tone_period_detector: measures square-wave tone period and identifies the note code.
// Optional macro TONE_DET_PERIOD_OUT_EN adds the Period output port.
module tone_period_detector
    import tone_pkg::*;
#(
    parameter int CNT_W     = 11,
    parameter int TOL       = 8,
    parameter int MATCH_CNT = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             Tone_in,
    output logic [1:0]       Note,
    output logic             Valid,
`ifdef TONE_DET_PERIOD_OUT_EN
    output logic [CNT_W-1:0] Period,
`endif
    output logic             Err
);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, period_q, period_d, period;
    logic [MW-1:0]     match_q, match_d;
    note_t             note_q, note_d, prev_q, prev_d, code;
    logic              valid_q, valid_d, err_q, err_d, rise, hit;
    logic signed [CNT_W:0] diff;
    edge_sync u_sync (.clk_i(Clk_in), .rst_ni(Rst), .d_i(Tone_in), .rise_o(rise));
    assign period = cnt_q + CNT_W'(1);
    // Windows are disjoint, so at most one code can hit.
    always_comb begin
        hit  = 1'b0;
        code = '0;
        diff = '0;
        for (int k = 0; k < 4; k++) begin
            diff = $signed({1'b0, period}) - $signed((CNT_W + 1)'(nominal(note_t'(k))));
            if (!hit && diff <= TOL_S && diff >= -TOL_S) begin
                hit  = 1'b1;
                code = note_t'(k);
            end
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        note_d   = note_q;
        prev_d   = prev_q;
        valid_d  = valid_q;
        period_d = period_q;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = rise ? MEASURE : IDLE;
        end else if (rise) begin
            cnt_d    = '0;
            period_d = period;
            if (!hit) begin
                err_d   = 1'b1;
                valid_d = 1'b0;
                match_d = '0;
            end else begin
                match_d = (match_q != '0 && code == prev_q)
                        ? ((match_q == MW'(MATCH_CNT)) ? match_q : match_q + MW'(1)) : MW'(1);
                valid_d = (match_d == MW'(MATCH_CNT));
                note_d  = valid_d ? code : note_q;
                prev_d  = code;
            end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            valid_d = 1'b0;
            match_d = '0;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            note_q   <= '0;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            note_q   <= note_d;
            prev_q   <= prev_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            period_q <= period_d;
        end
    end
    assign Note  = note_q;
    assign Valid = valid_q;
    assign Err   = err_q;
`ifdef TONE_DET_PERIOD_OUT_EN
    assign Period = period_q;
`else
    logic unused_period;
    assign unused_period = ^period_q;
`endif
endmodule

// File: tb/tb_tone_period_detector.sv
// tb_tone_period_detector: table vectors, hand corner sequences and a randomized model check.
module tb_tone_period_detector;
    localparam int TIMEOUT = 1023;
    typedef struct { int p; bit v; int n; bit e; } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, tone = 1'b0;
    logic [1:0] note;
    logic valid, err;
`ifdef TONE_DET_PERIOD_OUT_EN
    logic [10:0] period;
`endif
    int total = 0, bad = 0, err_total = 0, err_snap = 0;
    int nom[4] = '{888, 670, 560, 444};
    int hist[$];
    int mnote = 0;
    vec_t tab[18];

    tone_period_detector dut (
        .Clk_in(clk), .Rst(rst_n), .Tone_in(tone), .Note(note), .Valid(valid),
`ifdef TONE_DET_PERIOD_OUT_EN
        .Period(period),
`endif
        .Err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (err) err_total++;

    task automatic cmp(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic chk(input string nm, input bit ev, input int en, input bit ee);
        cmp({nm, ".valid"}, int'(valid), int'(ev));
        cmp({nm, ".note"}, int'(note), en);
        cmp({nm, ".err_pulses"}, err_total - err_snap, int'(ee));
    endtask

    task automatic edge_rise();
        tone = 1'b1;
        err_snap = err_total;
        repeat (8) @(negedge clk);
    endtask

    task automatic rest(input int p);
        repeat (p / 2 - 8) @(negedge clk);
        tone = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic one_period(input int p, input string nm, input bit ev, input int en, input bit ee);
        rest(p);
        edge_rise();
        chk(nm, ev, en, ee);
`ifdef TONE_DET_PERIOD_OUT_EN
        cmp({nm, ".period"}, int'(period), p);
`endif
    endtask

    function automatic int classify(input int p);
        for (int k = 0; k < 4; k++)
            if (p - nom[k] <= 8 && nom[k] - p <= 8) return k;
        return -1;
    endfunction

    // Valid means the three most recent periods since the last idle share one code.
    task automatic model_check(input int p, input string nm);
        int c, sz;
        bit ev;
        c = classify(p);
        hist.push_back(c);
        sz = hist.size();
        ev = sz >= 3 && c >= 0 && hist[sz-2] == c && hist[sz-3] == c;
        if (ev) mnote = c;
        one_period(p, nm, ev, mnote, c < 0);
    endtask

    initial begin
        tab[0]  = '{888, 0, 0, 0}; tab[1]  = '{888, 0, 0, 0}; tab[2]  = '{888, 1, 0, 0};
        tab[3]  = '{444, 0, 0, 0}; tab[4]  = '{444, 0, 0, 0}; tab[5]  = '{450, 1, 3, 0};
        tab[6]  = '{453, 0, 3, 1}; tab[7]  = '{670, 0, 3, 0}; tab[8]  = '{670, 0, 3, 0};
        tab[9]  = '{670, 1, 1, 0}; tab[10] = '{560, 0, 1, 0}; tab[11] = '{560, 0, 1, 0};
        tab[12] = '{560, 1, 2, 0}; tab[13] = '{880, 0, 2, 0}; tab[14] = '{896, 0, 2, 0};
        tab[15] = '{897, 0, 2, 1}; tab[16] = '{436, 0, 2, 0}; tab[17] = '{435, 0, 2, 1};
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("in_reset", 0, 0, 0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_after_reset", 0, 0, 0);
`ifdef TONE_DET_PERIOD_OUT_EN
        cmp("idle_after_reset.period", int'(period), 0);
`endif
        edge_rise();
        chk("first_edge", 0, 0, 0);
        foreach (tab[i]) one_period(tab[i].p, $sformatf("vec%0d", i), tab[i].v, tab[i].n, tab[i].e);
        // Lock on note 1, then let the tone stop and watch the timeout.
        one_period(670, "lock1_a", 0, 2, 0);
        one_period(670, "lock1_b", 0, 2, 0);
        one_period(670, "lock1_c", 1, 1, 0);
        repeat (200 - 8) @(negedge clk);
        tone = 1'b0;
        repeat (TIMEOUT + 3 - 200) @(negedge clk);
        chk("before_timeout", 1, 1, 0);
        @(negedge clk);
        chk("timeout_drop", 0, 1, 0);
        edge_rise();
        chk("reentry_edge", 0, 1, 0);
        one_period(670, "relock_a", 0, 1, 0);
        one_period(670, "relock_b", 0, 1, 0);
        one_period(670, "relock_c", 1, 1, 0);
        one_period(TIMEOUT, "rise_at_timeout", 0, 1, 1);
        rest(TIMEOUT + 1);
        edge_rise();
        chk("timeout_plus1", 0, 1, 0);
        one_period(560, "p560_a", 0, 1, 0);
        one_period(560, "p560_b", 0, 1, 0);
        one_period(560, "p560_c", 1, 2, 0);
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        cmp("async_reset.valid", int'(valid), 0);
        cmp("async_reset.note", int'(note), 0);
        cmp("async_reset.err", int'(err), 0);
`ifdef TONE_DET_PERIOD_OUT_EN
        cmp("async_reset.period", int'(period), 0);
`endif
        tone = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        edge_rise();
        one_period(560, "postrst_a", 0, 0, 0);
        one_period(560, "postrst_b", 0, 0, 0);
        one_period(560, "postrst_c", 1, 2, 0);
        // Randomized section: go idle first so the model starts from an empty history.
        repeat (100 - 8) @(negedge clk);
        tone = 1'b0;
        repeat (TIMEOUT + 20) @(negedge clk);
        hist.delete();
        mnote = 2;
        edge_rise();
        begin
            int k = 0, p;
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    repeat (100 - 8) @(negedge clk);
                    tone = 1'b0;
                    repeat (TIMEOUT + $urandom_range(5, 100)) @(negedge clk);
                    hist.delete();
                    edge_rise();
                    chk($sformatf("rnd%0d_idle", i), 0, mnote, 0);
                end else begin
                    if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 3);
                    p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(300, 1000))
                                                    : nom[k] + int'($urandom_range(0, 20)) - 10;
                    model_check(p, $sformatf("rnd%0d_p%0d", i, p));
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
